// File: rtl/conv_stream_param.sv
// Parametrised 1-D valid-mode convolution engine: loads X and F over stream ports,
// then streams y[k] = sum x[k+i]*f[i] through a pipelined adder tree and output FIFO.
module conv_stream_param #(
  parameter int unsigned DATA_WIDTH_X   = 8,
  parameter int unsigned DATA_WIDTH_F   = 8,
  parameter int unsigned X_SIZE         = 128,
  parameter int unsigned F_SIZE         = 32,
  parameter int unsigned ACC_SIZE       = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE),
  parameter int unsigned OUT_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid_x,
  output logic                           s_ready_x,
  input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
  input  logic                           s_valid_f,
  output logic                           s_ready_f,
  input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
  input  logic                           cfg_relu,
  input  logic                           cfg_keep_f,
  output logic                           m_valid_y,
  input  logic                           m_ready_y,
  output logic signed [ACC_SIZE-1:0]     m_data_out_y,
  output logic                           busy
);

  localparam int unsigned T     = $clog2(F_SIZE);
  localparam int unsigned N_OUT = X_SIZE - F_SIZE + 1;
  localparam int unsigned PW    = DATA_WIDTH_X + DATA_WIDTH_F;
  localparam int unsigned XAW   = $clog2(X_SIZE);
  localparam int unsigned XCW   = $clog2(X_SIZE + 1);
  localparam int unsigned FAW   = $clog2(F_SIZE);
  localparam int unsigned FCW   = $clog2(F_SIZE + 1);
  localparam int unsigned QAW   = $clog2(OUT_FIFO_DEPTH);
  localparam int unsigned QCW   = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int unsigned IW    = $clog2(T + 2);

  typedef enum logic [1:0] {ST_LOAD, ST_CONV, ST_DRAIN} state_t;

  state_t                         state;
  logic [XCW-1:0]                 x_cnt;
  logic [FCW-1:0]                 f_cnt;
  logic                           f_loaded;
  logic [XAW-1:0]                 issue_cnt;
  logic                           relu_q;
  logic                           keep_q;
  logic [T:0]                     v_q;

  logic signed [DATA_WIDTH_X-1:0] x_mem  [X_SIZE];
  logic signed [DATA_WIDTH_F-1:0] f_mem  [F_SIZE];
  logic signed [DATA_WIDTH_X-1:0] win_q  [F_SIZE];
  logic signed [PW-1:0]           prod   [F_SIZE];
  logic signed [ACC_SIZE-1:0]     tree_q [T][F_SIZE];
  logic signed [ACC_SIZE-1:0]     tree_sum;
  logic signed [ACC_SIZE-1:0]     push_data;

  logic signed [ACC_SIZE-1:0]     fifo_mem [OUT_FIFO_DEPTH];
  logic [QAW-1:0]                 wr_ptr;
  logic [QAW-1:0]                 rd_ptr;
  logic [QCW-1:0]                 fifo_cnt;

  logic                           x_acc, f_acc, x_full_n, f_full_n;
  logic                           push, pop, issue;
  logic [IW-1:0]                  inflight;

  assign s_ready_x    = (state == ST_LOAD) && (x_cnt < XCW'(X_SIZE));
  assign s_ready_f    = (state == ST_LOAD) && !f_loaded && (f_cnt < FCW'(F_SIZE));
  assign busy         = (state != ST_LOAD);
  assign m_valid_y    = (fifo_cnt != '0);
  assign m_data_out_y = fifo_mem[rd_ptr];

  assign x_acc    = s_valid_x && s_ready_x;
  assign f_acc    = s_valid_f && s_ready_f;
  assign x_full_n = (x_cnt == XCW'(X_SIZE)) || (x_acc && (x_cnt == XCW'(X_SIZE - 1)));
  assign f_full_n = f_loaded || (f_acc && (f_cnt == FCW'(F_SIZE - 1)));
  assign pop      = m_valid_y && m_ready_y;
  assign push     = v_q[T];

  // Credit: every issued window owns a FIFO slot; a pop this cycle frees one.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= int'(T); i++) inflight = inflight + IW'(v_q[i]);
  end

  assign issue = (state == ST_CONV) &&
                 ((32'(fifo_cnt) + 32'(inflight)) < (OUT_FIFO_DEPTH + 32'(pop)));

  always_comb begin
    for (int i = 0; i < int'(F_SIZE); i++)
      prod[i] = PW'(win_q[i]) * PW'(f_mem[i]);
  end

  // The last adder level is combinational and lands directly in the FIFO.
  assign tree_sum  = tree_q[T-1][0] + tree_q[T-1][1];
  assign push_data = (relu_q && tree_sum[ACC_SIZE-1]) ? '0 : tree_sum;

  always_ff @(posedge clk) begin
    if (x_acc) x_mem[XAW'(x_cnt)] <= s_data_in_x;
    if (f_acc) f_mem[FAW'(f_cnt)] <= s_data_in_f;
  end

  // Free-running datapath: window, products, registered adder levels.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(F_SIZE); i++) begin
      win_q[i]     <= x_mem[issue_cnt + XAW'(i)];
      tree_q[0][i] <= ACC_SIZE'(prod[i]);
    end
    for (int l = 1; l < int'(T); l++) begin
      for (int j = 0; j < int'(F_SIZE / 2); j++)
        tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
      for (int j = int'(F_SIZE / 2); j < int'(F_SIZE); j++)
        tree_q[l][j] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      x_cnt     <= '0;
      f_cnt     <= '0;
      f_loaded  <= 1'b0;
      issue_cnt <= '0;
      relu_q    <= 1'b0;
      keep_q    <= 1'b0;
      v_q       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      for (int i = 0; i < int'(OUT_FIFO_DEPTH); i++) fifo_mem[i] <= '0;
    end else begin
      v_q <= {v_q[T-1:0], issue};

      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr <= (wr_ptr == QAW'(OUT_FIFO_DEPTH - 1)) ? '0 : wr_ptr + QAW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == QAW'(OUT_FIFO_DEPTH - 1)) ? '0 : rd_ptr + QAW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + QCW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - QCW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        ST_LOAD: begin
          if (x_acc) x_cnt <= x_cnt + XCW'(1);
          if (f_acc) f_cnt <= f_cnt + FCW'(1);
          if (f_acc && (f_cnt == FCW'(F_SIZE - 1))) f_loaded <= 1'b1;
          if (x_full_n && f_full_n) begin
            state     <= ST_CONV;
            relu_q    <= cfg_relu;
            keep_q    <= cfg_keep_f;
            issue_cnt <= '0;
          end
        end
        ST_CONV: begin
          if (issue) begin
            if (issue_cnt == XAW'(N_OUT - 1)) begin
              state     <= ST_DRAIN;
              issue_cnt <= '0;
            end else begin
              issue_cnt <= issue_cnt + XAW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((v_q == '0) && ((fifo_cnt == '0) || ((fifo_cnt == QCW'(1)) && pop))) begin
            state <= ST_LOAD;
            x_cnt <= '0;
            if (!keep_q) begin
              f_loaded <= 1'b0;
              f_cnt    <= '0;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_param.sv
// Bench for conv_stream_param: a small (X=8,F=4) and a default (X=128,F=32) instance,
// each checked against a scoreboard of bench-computed Y values.
module tb_conv_stream_param;

  localparam int XS = 8;
  localparam int FS = 4;
  localparam int NS = XS - FS + 1;
  localparam int XD = 128;
  localparam int FD = 32;
  localparam int ND = XD - FD + 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // small instance signals
  logic reset_s, vx_s, rx_s, vf_s, rf_s, relu_s, keep_s, vy_s, ry_s, busy_s;
  logic signed [7:0]  dx_s, df_s;
  logic signed [17:0] y_s;
  // default instance signals
  logic reset_d, vx_d, rx_d, vf_d, rf_d, relu_d, keep_d, vy_d, ry_d, busy_d;
  logic signed [7:0]  dx_d, df_d;
  logic signed [20:0] y_d;

  conv_stream_param #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(XS), .F_SIZE(FS),
                      .OUT_FIFO_DEPTH(DEPTH)) dut_s (
    .clk(clk), .reset(reset_s),
    .s_valid_x(vx_s), .s_ready_x(rx_s), .s_data_in_x(dx_s),
    .s_valid_f(vf_s), .s_ready_f(rf_s), .s_data_in_f(df_s),
    .cfg_relu(relu_s), .cfg_keep_f(keep_s),
    .m_valid_y(vy_s), .m_ready_y(ry_s), .m_data_out_y(y_s), .busy(busy_s));

  conv_stream_param dut_d (
    .clk(clk), .reset(reset_d),
    .s_valid_x(vx_d), .s_ready_x(rx_d), .s_data_in_x(dx_d),
    .s_valid_f(vf_d), .s_ready_f(rf_d), .s_data_in_f(df_d),
    .cfg_relu(relu_d), .cfg_keep_f(keep_d),
    .m_valid_y(vy_d), .m_ready_y(ry_d), .m_data_out_y(y_d), .busy(busy_d));

  int xv_s [XS];
  int fv_s [FS];
  int xv_d [XD];
  int fv_d [FD];
  int q_s [$];
  int q_d [$];
  int nout_s, first_s, lastout_s, last_acc_s;
  int nout_d, first_d, last_acc_d;
  bit bp_s = 1'b0;
  bit stall_s = 1'b0;
  int held_s;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic int ref_s(input int k, input bit relu);
    int acc = 0;
    for (int i = 0; i < FS; i++) acc += xv_s[k+i] * fv_s[i];
    return (relu && acc < 0) ? 0 : acc;
  endfunction

  function automatic int ref_d(input int k, input bit relu);
    int acc = 0;
    for (int i = 0; i < FD; i++) acc += xv_d[k+i] * fv_d[i];
    return (relu && acc < 0) ? 0 : acc;
  endfunction

  // ready pattern for the small instance: always 1, or ~30% stalls
  initial begin
    ry_s = 1'b1;
    forever begin
      @(posedge clk); #1;
      ry_s = bp_s ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // small monitor: scoreboard compare, stall stability, FIFO bound
  always @(negedge clk) begin
    if (!reset_s) begin
      if (stall_s) begin
        chk("hold_valid_s", int'(vy_s), 1);
        chk("hold_data_s", int'(y_s), held_s);
      end
      stall_s = 1'b0;
      if (vy_s) begin
        if (nout_s == 0) first_s = cyc;
        if (ry_s) begin
          chk("q_s_nonempty", int'(q_s.size() > 0), 1);
          if (q_s.size() > 0) chk("y_s", int'(y_s), q_s.pop_front());
          nout_s++;
          lastout_s = cyc;
        end else begin
          stall_s = 1'b1;
          held_s  = int'(y_s);
        end
      end
      chk("fifo_cnt_s", int'(dut_s.fifo_cnt <= 3'(DEPTH)), 1);
    end
  end

  // default monitor
  always @(negedge clk) begin
    if (!reset_d) begin
      if (vy_d && ry_d) begin
        if (nout_d == 0) first_d = cyc;
        chk("q_d_nonempty", int'(q_d.size() > 0), 1);
        if (q_d.size() > 0) chk("y_d", int'(y_d), q_d.pop_front());
        nout_d++;
      end
      chk("fifo_cnt_d", int'(dut_d.fifo_cnt <= 3'(DEPTH)), 1);
    end
  end

  task automatic load_s(input bit sx, input bit sf);
    int xi, fi, n;
    xi = sx ? 0 : XS;
    fi = sf ? 0 : FS;
    n  = 0;
    while ((xi < XS || fi < FS) && n < 400) begin
      vx_s = (xi < XS); dx_s = 8'(xv_s[(xi < XS) ? xi : 0]);
      vf_s = (fi < FS); df_s = 8'(fv_s[(fi < FS) ? fi : 0]);
      @(negedge clk);
      if (vx_s && rx_s) begin xi++; last_acc_s = cyc; end
      if (vf_s && rf_s) begin fi++; last_acc_s = cyc; end
      @(posedge clk); #1;
      n++;
    end
    vx_s = 1'b0; vf_s = 1'b0;
    chk("load_s_done", int'(xi >= XS && fi >= FS), 1);
  endtask

  task automatic load_d(input bit sx, input bit sf);
    int xi, fi, n;
    xi = sx ? 0 : XD;
    fi = sf ? 0 : FD;
    n  = 0;
    while ((xi < XD || fi < FD) && n < 1000) begin
      vx_d = (xi < XD); dx_d = 8'(xv_d[(xi < XD) ? xi : 0]);
      vf_d = (fi < FD); df_d = 8'(fv_d[(fi < FD) ? fi : 0]);
      @(negedge clk);
      if (vx_d && rx_d) begin xi++; last_acc_d = cyc; end
      if (vf_d && rf_d) begin fi++; last_acc_d = cyc; end
      @(posedge clk); #1;
      n++;
    end
    vx_d = 1'b0; vf_d = 1'b0;
    chk("load_d_done", int'(xi >= XD && fi >= FD), 1);
  endtask

  task automatic push_s();
    for (int k = 0; k < NS; k++) q_s.push_back(ref_s(k, relu_s));
  endtask

  task automatic wait_s(input string tag);
    int n = 0;
    while ((q_s.size() != 0 || busy_s) && n < 2000) begin @(posedge clk); #1; n++; end
    chk({tag, "_drained"}, q_s.size(), 0);
    chk({tag, "_count"}, nout_s, NS);
  endtask

  task automatic wait_d(input string tag);
    int n = 0;
    while ((q_d.size() != 0 || busy_d) && n < 4000) begin @(posedge clk); #1; n++; end
    chk({tag, "_drained"}, q_d.size(), 0);
    chk({tag, "_count"}, nout_d, ND);
  endtask

  initial begin
    int n;
    reset_s = 1'b1; reset_d = 1'b1;
    vx_s = 0; vf_s = 0; dx_s = '0; df_s = '0; relu_s = 0; keep_s = 0;
    vx_d = 0; vf_d = 0; dx_d = '0; df_d = '0; relu_d = 0; keep_d = 0; ry_d = 1'b1;
    nout_s = 0; nout_d = 0; first_s = 0; first_d = 0; lastout_s = 0;
    last_acc_s = 0; last_acc_d = 0;
    repeat (3) @(posedge clk);
    #1; reset_s = 1'b0; reset_d = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_ready_x", int'(rx_s), 1);
    chk("rst_ready_f", int'(rf_s), 1);
    chk("rst_valid_y", int'(vy_s), 0);
    chk("rst_data_y", int'(y_s), 0);
    chk("rst_busy", int'(busy_s), 0);
    chk("rst_busy_d", int'(busy_d), 0);
    @(posedge clk); #1;

    // basic: x=1..8, f=1,1,1,1 -> 10,14,18,22,26
    for (int i = 0; i < XS; i++) xv_s[i] = i + 1;
    for (int i = 0; i < FS; i++) fv_s[i] = 1;
    for (int k = 0; k < NS; k++) q_s.push_back(10 + 4 * k);
    nout_s = 0;
    load_s(1, 1);
    wait_s("basic");
    chk("basic_latency", first_s - last_acc_s, 5);
    chk("basic_consecutive", lastout_s - first_s, NS - 1);

    // relu on and off with f=1,-1,0,0
    fv_s[0] = 1; fv_s[1] = -1; fv_s[2] = 0; fv_s[3] = 0;
    relu_s = 1; nout_s = 0;
    for (int k = 0; k < NS; k++) q_s.push_back(0);
    load_s(1, 1);
    wait_s("relu_on");
    relu_s = 0; nout_s = 0;
    for (int k = 0; k < NS; k++) q_s.push_back(-1);
    load_s(1, 1);
    wait_s("relu_off");

    // backpressure with random data
    bp_s = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < XS; i++) xv_s[i] = rnd8();
      for (int i = 0; i < FS; i++) fv_s[i] = rnd8();
      nout_s = 0;
      load_s(1, 1);
      push_s();
      wait_s("bp");
    end
    bp_s = 1'b0;

    // filter retention
    keep_s = 1; nout_s = 0;
    for (int i = 0; i < XS; i++) xv_s[i] = rnd8();
    for (int i = 0; i < FS; i++) fv_s[i] = rnd8();
    load_s(1, 1);
    push_s();
    wait_s("keep_v1");
    @(negedge clk);
    chk("keep_ready_f", int'(rf_s), 0);
    chk("keep_ready_x", int'(rx_s), 1);
    @(posedge clk); #1;
    keep_s = 0; nout_s = 0;
    for (int i = 0; i < XS; i++) xv_s[i] = rnd8();
    load_s(1, 0);
    push_s();
    wait_s("keep_v2");
    @(negedge clk);
    chk("nokeep_ready_f", int'(rf_s), 1);
    @(posedge clk); #1;
    nout_s = 0;
    for (int i = 0; i < XS; i++) xv_s[i] = rnd8();
    load_s(1, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("nokeep_wait_busy", int'(busy_s), 0);
    chk("nokeep_wait_ready_x", int'(rx_s), 0);
    @(posedge clk); #1;
    for (int i = 0; i < FS; i++) fv_s[i] = rnd8();
    load_s(0, 1);
    push_s();
    wait_s("nokeep_v3");

    // default params: extreme magnitudes, retained F
    for (int i = 0; i < XD; i++) xv_d[i] = -128;
    for (int i = 0; i < FD; i++) fv_d[i] = -128;
    keep_d = 1; nout_d = 0;
    load_d(1, 1);
    for (int k = 0; k < ND; k++) q_d.push_back(524288);
    wait_d("max_pos");
    chk("max_pos_latency", first_d - last_acc_d, 8);
    @(negedge clk);
    chk("d_keep_ready_f", int'(rf_d), 0);
    @(posedge clk); #1;
    for (int i = 0; i < XD; i++) xv_d[i] = 127;
    keep_d = 0; nout_d = 0;
    load_d(1, 0);
    for (int k = 0; k < ND; k++) q_d.push_back(-520192);
    wait_d("max_neg");

    // reset mid-CONV after three outputs
    for (int i = 0; i < XD; i++) xv_d[i] = rnd8();
    for (int i = 0; i < FD; i++) fv_d[i] = rnd8();
    nout_d = 0;
    load_d(1, 1);
    for (int k = 0; k < ND; k++) q_d.push_back(ref_d(k, 1'b0));
    n = 0;
    while (nout_d < 3 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("midrst_outputs_seen", int'(nout_d >= 3), 1);
    chk("midrst_in_conv", int'(dut_d.state == 2'd1), 1);
    reset_d = 1'b1;
    @(posedge clk); #1;
    reset_d = 1'b0;
    q_d.delete();
    @(negedge clk);
    chk("midrst_valid_y", int'(vy_d), 0);
    chk("midrst_ready_x", int'(rx_d), 1);
    chk("midrst_ready_f", int'(rf_d), 1);
    chk("midrst_busy", int'(busy_d), 0);
    @(posedge clk); #1;
    for (int i = 0; i < XD; i++) xv_d[i] = rnd8();
    for (int i = 0; i < FD; i++) fv_d[i] = rnd8();
    relu_d = 1; nout_d = 0;
    load_d(1, 1);
    for (int k = 0; k < ND; k++) q_d.push_back(ref_d(k, 1'b1));
    wait_d("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_stream_param.md
Name: conv_stream_param

Overview:
- Parametrised 1-D valid-mode convolution engine: y[k] = sum over i of x[k+i]*f[i], for k = 0..X_SIZE-F_SIZE.
- X and F are loaded over AXI-stream-style slave ports; Y is emitted on a master port.
- Generalises the fixed 128/32 engine with a generic log2(F_SIZE)-level adder tree, a credit-controlled output FIFO, optional ReLU, and filter retention across X vectors.
- Sits between the input DMA streams and the downstream layer.

Parameters:
- DATA_WIDTH_X, 8, signed X sample width.
- DATA_WIDTH_F, 8, signed F coefficient width.
- X_SIZE, 128, X vector length; must be greater than F_SIZE.
- F_SIZE, 32, filter length; power of two, at least 2.
- ACC_SIZE, DATA_WIDTH_X+DATA_WIDTH_F+$clog2(F_SIZE), output width; must not be smaller than the default.
- OUT_FIFO_DEPTH, 4, output FIFO entries; at least 2.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- s_valid_x, input, 1, X word valid.
- s_ready_x, output, 1, X word accepted when valid and ready are both high.
- s_data_in_x, input, DATA_WIDTH_X, signed X word.
- s_valid_f, input, 1, F word valid.
- s_ready_f, output, 1, F ready.
- s_data_in_f, input, DATA_WIDTH_F, signed F word.
- cfg_relu, input, 1, clamp negative outputs to 0; sampled on entry to CONV.
- cfg_keep_f, input, 1, retain F for the next vector; sampled on entry to CONV.
- m_valid_y, output, 1, Y word valid.
- m_ready_y, input, 1, downstream ready.
- m_data_out_y, output, ACC_SIZE, signed Y word.
- busy, output, 1, high in CONV or DRAIN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset values:
  - s_ready_x=1, s_ready_f=1, m_valid_y=0, m_data_out_y=0, busy=0.
  - State=LOAD, all counters 0, f_loaded=0, FIFO empty, pipeline valid bits 0.
- N_OUT = X_SIZE-F_SIZE+1. T = log2(F_SIZE).
- LOAD state:
  - s_ready_x = (x_cnt < X_SIZE). s_ready_f = !f_loaded && (f_cnt < F_SIZE).
  - Each accepted word is written at address x_cnt or f_cnt, and that counter increments.
  - X and F loading may proceed simultaneously, in any interleave.
  - f_loaded sets when f_cnt reaches F_SIZE.
  - Go to CONV in the cycle after x_cnt==X_SIZE and f_loaded are both true. Latch cfg_relu and cfg_keep_f on that transition.
- CONV state:
  - Both ready outputs are 0.
  - Each cycle, issue window k = issue_cnt if credit > 0. credit = OUT_FIFO_DEPTH - fifo_count - inflight.
  - A valid bit travels with each window.
  - After issuing k = N_OUT-1, go to DRAIN.
- Pipeline (free-running; no global stall, because credits guarantee FIFO space):
  - Stage 0: register F_SIZE window samples x[k..k+F_SIZE-1].
  - Stage 1: register F_SIZE full-width products (DATA_WIDTH_X+DATA_WIDTH_F).
  - Stages 2..T+1: pairwise adder levels, each sign-extended to ACC_SIZE and registered.
  - Apply ReLU combinationally before the FIFO write.
  - The final adder level writes into the FIFO.
  - No overflow is possible at ACC_SIZE >= default.
- Latency: a window issued in cycle c reaches the FIFO at the end of cycle c+T+1. With an empty FIFO, m_valid_y rises at c+T+2.
  - Example, F_SIZE=32 with the last input accepted in cycle t: first m_valid_y at t+8.
- Output FIFO:
  - m_valid_y = !empty; m_data_out_y = head entry, held stable while valid and not ready.
  - Push and pop in the same cycle are both allowed when full or empty-with-push; count stays consistent.
  - Overflow never occurs. If it would, it is a design error; the bench asserts on it.
- DRAIN state:
  - When the pipeline is empty and the final FIFO entry is popped, go to LOAD.
  - Clear x_cnt. If keep_f is latched, keep f_loaded and f_cnt; otherwise clear them.
  - s_ready_x reasserts in the first LOAD cycle.
- Throughput: one Y per cycle when m_ready_y is held high (credit never starves at OUT_FIFO_DEPTH >= T+2). Shallower FIFOs throttle issue but stay correct.
- reset in any state returns all state to reset values within one edge. In-flight and FIFO data are discarded; f_loaded is cleared.
- Loading X while busy is not supported (single buffer).

Test Plan:
- Basic: F_SIZE=4, X_SIZE=8, x=1..8, f=1,1,1,1, m_ready_y=1 -> Y = 10,14,18,22,26. Outputs on consecutive cycles; first at last-accept+5.
- Default params: x[i]=-128, f[i]=-128 -> all 97 outputs = 524288. x[i]=127, f[i]=-128 -> -520192. No wrap at ACC_SIZE=21.
- Backpressure: m_ready_y random 30% -> identical Y sequence vs. model. Data held stable under stall. FIFO count never exceeds OUT_FIFO_DEPTH. No lost or duplicate words.
- ReLU: f=1,-1,0,0, x=1..8, cfg_relu=1 -> all Y=0 (raw -1). With cfg_relu=0 -> all Y=-1.
- Filter retention: cfg_keep_f=1 on vector 1, then send only X for vector 2 -> s_ready_f stays 0, vector 2 uses the old F. With keep_f=0 -> F is required again.
- Reset mid-CONV, after 3 outputs: m_valid_y=0 next cycle, s_ready_x=s_ready_f=1. A fresh full load produces a correct result.
